// File: rtl/parity_serial_tx_pkg.sv
// Shared types and frame constants for parity_serial_tx.
// PARITY_SERIAL_TX_TWO_STOP_EN selects two stop bits instead of one.
package parity_serial_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int unsigned DATA_W = 8;

`ifdef PARITY_SERIAL_TX_TWO_STOP_EN
   localparam int unsigned STOP_BITS = 2;
`else
   localparam int unsigned STOP_BITS = 1;
`endif

   // start + data + parity + stop
   localparam int unsigned FRAME_BITS = 1 + DATA_W + 1 + STOP_BITS;

endpackage

// File: rtl/parity_serial_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit with o_bit_end.
module parity_serial_tx_baud #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_bit_end
);

   localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

   logic [7:0] r_cnt;
   logic       w_last;

   assign w_last    = (r_cnt == CNT_LAST);
   assign o_bit_end = i_en & w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_en || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter: start, 8 data bits LSB first, even/odd parity, stop.
// Define PARITY_SERIAL_TX_TWO_STOP_EN for two stop bits.
module parity_serial_tx
   import parity_serial_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              parity_sel,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   state_t            r_state, w_state_n;
   logic [2:0]        r_idx, w_idx_n, w_idx_inc;
   logic              r_stop, w_stop_n;
   logic              r_tx, w_tx_n;
   logic [DATA_W-1:0] r_data;
   logic              r_par;
   logic              w_accept;
   logic              w_bit_end;
   logic              w_done;

   parity_serial_tx_baud #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (r_state != S_IDLE),
      .o_bit_end(w_bit_end)
   );

   assign w_idx_inc  = r_idx + 3'd1;
   assign tx_ready   = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign tx_out     = r_tx;
   assign frame_done = w_done;

   // tx_out is registered, so the line value for the next state is chosen here
   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_stop_n  = r_stop;
      w_tx_n    = r_tx;
      w_accept  = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_n = 1'b1;
            if (tx_valid) begin
               w_accept  = 1'b1;
               w_state_n = S_START;
               w_idx_n   = '0;
               w_stop_n  = 1'b0;
               w_tx_n    = 1'b0;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_n = S_DATA;
               w_idx_n   = '0;
               w_tx_n    = r_data[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == 3'd7) begin
                  w_state_n = S_PARITY;
                  w_tx_n    = r_par;
               end else begin
                  w_idx_n = w_idx_inc;
                  w_tx_n  = r_data[w_idx_inc];
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_n = S_STOP;
               w_tx_n    = 1'b1;
            end
         end
         S_STOP: begin
            w_tx_n = 1'b1;
            if (w_bit_end) begin
               if (r_stop == STOP_LAST) begin
                  w_state_n = S_IDLE;
                  w_done    = 1'b1;
               end else begin
                  w_stop_n = r_stop + 1'b1;
               end
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_stop  <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_stop  <= w_stop_n;
         r_tx    <= w_tx_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_par  <= 1'b0;
      end else if (w_accept) begin
         r_data <= data_in;
         r_par  <= (^data_in) ^ parity_sel;
      end
   end

endmodule
